hamming84_decoder: RTL and testbench

- Serial receive-side decoder for the 8-bit framed Hamming(7,4) codeword produced by the transmit encoder.
- Deserialises one 8-bit frame, checks the marker bit, computes the 3-bit syndrome and corrects any single-bit error.
- Re-serialises the recovered 4-bit nibble on `out` with a valid strobe.
- Sits between the channel/demodulator bit stream and the downstream data sink.

---
 rtl/hamming84_decoder.sv | 148 ++++++++++++++
 tb/tb_hamming84_decoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming84_decoder.sv
// Serial receive-side decoder for 8-bit framed Hamming(7,4) codewords.
// Collects one LSB-first frame, checks the marker bit, corrects any single-bit
// error using the 3-bit syndrome, then replays the nibble d3 first with a strobe.

module hamming84_decoder #(
    parameter int MARKER_CHECK = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    output logic             out,
    output logic             osig,
    output logic             corr,
    output logic             mark_err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_RECV,
        ST_CHECK,
        ST_SEND
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Receive path state
    logic [2:0]       r_bitCnt;
    logic [7:0]       r_shift;

    // Output stage state
    state_t           r_state;
    logic [1:0]       r_sendIdx;
    logic [3:0]       r_data;
    logic             r_out;
    logic             r_osig;
    logic             r_corr;
    logic             r_markErr;
    logic [CNT_W-1:0] r_errCnt;

    // Decode wires
    logic             w_frameDone;
    logic [2:0]       w_syn;
    logic [3:0]       w_rxData;
    logic [3:0]       w_fixData;
    logic             w_markerOk;
    logic             w_synNonZero;

    // The frame completes on the cycle that captures bit 7.
    assign w_frameDone = in_valid && (r_bitCnt == 3'd7);

    // Shift bits in from the top so that, once full, r_shift[i] holds frame bit i.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitCnt <= 3'd0;
            r_shift  <= 8'd0;
        end else if (in_valid) begin
            r_shift  <= {in, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 3'd1;
        end else begin
            r_bitCnt <= 3'd0;
        end
    end

    assign w_rxData = r_shift[6:3];

    assign w_syn[2] = r_shift[2] ^ r_shift[6] ^ r_shift[4] ^ r_shift[3];
    assign w_syn[1] = r_shift[1] ^ r_shift[6] ^ r_shift[5] ^ r_shift[4];
    assign w_syn[0] = r_shift[0] ^ r_shift[5] ^ r_shift[4] ^ r_shift[3];

    assign w_synNonZero = (w_syn != 3'b000);

    assign w_markerOk = (MARKER_CHECK == 0) || r_shift[7];

    // Map the syndrome onto the data bit it points at; parity-only hits leave data alone.
    always_comb begin
        w_fixData = w_rxData;
        case (w_syn)
            3'b110:  w_fixData[3] = ~w_rxData[3];
            3'b011:  w_fixData[2] = ~w_rxData[2];
            3'b111:  w_fixData[1] = ~w_rxData[1];
            3'b101:  w_fixData[0] = ~w_rxData[0];
            default: w_fixData = w_rxData;
        endcase
    end

    // Output FSM: latch the decoded frame one cycle after capture, then shift it out d3 first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RECV;
            r_sendIdx <= 2'd0;
            r_data    <= 4'd0;
            r_out     <= 1'b0;
            r_osig    <= 1'b0;
            r_corr    <= 1'b0;
            r_markErr <= 1'b0;
            r_errCnt  <= '0;
        end else begin
            r_markErr <= 1'b0;
            case (r_state)
                ST_RECV: begin
                    if (w_frameDone) begin
                        r_state   <= ST_CHECK;
                        r_markErr <= (MARKER_CHECK != 0) && !in;
                    end
                end
                ST_CHECK: begin
                    if (w_markerOk) begin
                        r_data    <= w_fixData;
                        r_corr    <= w_synNonZero;
                        r_out     <= w_fixData[3];
                        r_osig    <= 1'b1;
                        r_sendIdx <= 2'd0;
                        r_state   <= ST_SEND;
                        if (w_synNonZero && (r_errCnt != CNT_MAX)) begin
                            r_errCnt <= r_errCnt + CNT_ONE;
                        end
                    end else begin
                        r_state <= ST_RECV;
                    end
                end
                ST_SEND: begin
                    if (r_sendIdx == 2'd3) begin
                        r_osig  <= 1'b0;
                        r_out   <= 1'b0;
                        r_state <= ST_RECV;
                    end else begin
                        r_sendIdx <= r_sendIdx + 2'd1;
                        r_out     <= r_data[2];
                        r_data    <= {r_data[2:0], 1'b0};
                    end
                end
                default: begin
                    r_state <= ST_RECV;
                end
            endcase
        end
    end

    assign out      = r_out;
    assign osig     = r_osig;
    assign corr     = r_corr;
    assign mark_err = r_markErr;
    assign err_cnt  = r_errCnt;

endmodule

// File: tb/tb_hamming84_decoder.sv
// Self-checking bench for hamming84_decoder.
// Two instances share one input stream: the default 8-bit counter and a 2-bit
// counter that saturates early. Expected outputs come from a nearest-codeword
// model and a per-cycle expectation schedule.

module tb_hamming84_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in;
    logic       in_valid;

    logic       out, osig, corr, mark_err;
    logic [7:0] err_cnt;
    logic       outS, osigS, corrS, markS;
    logic [1:0] cntS;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit monEn  = 1'b0;

    // Expected per-cycle behaviour, keyed by cycle number
    bit expOsig[int];
    bit expOut[int];
    bit expMark[int];

    // Values that change at a known cycle: counter and corr flag
    int cntPrev = 0, cntNew = 0, cntChg = 0;
    bit corrPrev = 1'b0, corrNew = 1'b0;
    int corrChg = 0;

    typedef struct {
        logic [7:0] frame;
        logic [3:0] data;
        logic       corr;
        logic       drop;
        int         gap;
    } vec_t;

    vec_t vecs[10];

    hamming84_decoder #(.MARKER_CHECK(1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .out(out), .osig(osig), .corr(corr), .mark_err(mark_err), .err_cnt(err_cnt)
    );

    hamming84_decoder #(.MARKER_CHECK(1), .CNT_W(2)) dutSat (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .out(outS), .osig(osigS), .corr(corrS), .mark_err(markS), .err_cnt(cntS)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expectations
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat(int v, int m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic [7:0] encode(logic [3:0] d, logic m);
        logic c0, c1, c2;
        c2 = d[3] ^ d[1] ^ d[0];
        c1 = d[3] ^ d[2] ^ d[1];
        c0 = d[2] ^ d[1] ^ d[0];
        return {m, d, c2, c1, c0};
    endfunction

    // Hamming(7,4) is perfect: every 7-bit word lies within distance 1 of exactly one codeword
    function automatic void nearest(input logic [7:0] f, output logic [3:0] d, output logic c);
        logic [7:0] cw;
        d = 4'd0;
        c = 1'b0;
        for (int n = 0; n < 16; n++) begin
            cw = encode(4'(n), 1'b0);
            if ($countones(cw[6:0] ^ f[6:0]) <= 1) begin
                d = 4'(n);
                c = (cw[6:0] != f[6:0]);
            end
        end
    endfunction

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(string tag, bit eOsig, bit eOut, bit eCorr, bit eMark, int eCnt);
        checkVal({tag, " osig"},         osig,     32'(eOsig));
        checkVal({tag, " out"},          out,      32'(eOut));
        checkVal({tag, " corr"},         corr,     32'(eCorr));
        checkVal({tag, " mark_err"},     mark_err, 32'(eMark));
        checkVal({tag, " err_cnt"},      err_cnt,  32'(sat(eCnt, 255)));
        checkVal({tag, " sat osig"},     osigS,    32'(eOsig));
        checkVal({tag, " sat out"},      outS,     32'(eOut));
        checkVal({tag, " sat corr"},     corrS,    32'(eCorr));
        checkVal({tag, " sat mark_err"}, markS,    32'(eMark));
        checkVal({tag, " sat err_cnt"},  cntS,     32'(sat(eCnt, 3)));
    endtask

    // Compare every cycle against the expectation schedule
    always @(negedge clk) begin
        bit eOsig, eOut, eMark, eCorr;
        int eCnt;
        if (monEn) begin
            eOsig = expOsig.exists(cyc) ? expOsig[cyc] : 1'b0;
            eOut  = expOut.exists(cyc)  ? expOut[cyc]  : 1'b0;
            eMark = expMark.exists(cyc) ? expMark[cyc] : 1'b0;
            eCnt  = (cyc >= cntChg)  ? cntNew  : cntPrev;
            eCorr = (cyc >= corrChg) ? corrNew : corrPrev;
            checkOutput($sformatf("cycle %0d", cyc), eOsig, eOut, eCorr, eMark, eCnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            tick();
            in_valid = 1'b0;
            in       = 1'($urandom_range(0, 1));
        end
    endtask

    // e is the capture edge of bit 7; outputs from that frame appear from cycle e on
    task automatic schedule(logic [3:0] d, logic c, logic drop, int e);
        if (drop) begin
            expMark[e] = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                expOsig[e + 1 + k] = 1'b1;
                expOut[e + 1 + k]  = d[3 - k];
            end
            corrPrev = (cyc >= corrChg) ? corrNew : corrPrev;
            corrNew  = c;
            corrChg  = e + 1;
            if (c) begin
                cntPrev = (cyc >= cntChg) ? cntNew : cntPrev;
                cntNew  = cntNew + 1;
                cntChg  = e + 1;
            end
        end
    endtask

    task automatic applyStimulus(logic [7:0] frame, logic [3:0] d, logic c, logic drop, int gap);
        for (int i = 0; i < 8; i++) begin
            tick();
            in_valid = 1'b1;
            in       = frame[i];
            if (i == 7) schedule(d, c, drop, cyc + 1);
        end
        idle(gap);
    endtask

    task automatic sendPartial(int n, bit endIdle);
        for (int i = 0; i < n; i++) begin
            tick();
            in_valid = 1'b1;
            in       = 1'($urandom_range(0, 1));
        end
        if (endIdle) idle(1);
    endtask

    task automatic applyReset();
        int r;
        int keys[$];
        tick();
        reset    = 1'b1;
        in_valid = 1'b0;
        r = cyc + 1;
        foreach (expOsig[k]) if (k >= r) keys.push_back(k);
        foreach (expMark[k]) if (k >= r) keys.push_back(k);
        foreach (keys[i]) begin
            expOsig.delete(keys[i]);
            expOut.delete(keys[i]);
            expMark.delete(keys[i]);
        end
        cntPrev  = (cyc >= cntChg) ? cntNew : cntPrev;
        cntNew   = 0;
        cntChg   = r;
        corrPrev = (cyc >= corrChg) ? corrNew : corrPrev;
        corrNew  = 1'b0;
        corrChg  = r;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("after reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Safety net so the run always ends
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        logic [7:0] f;
        logic [3:0] d, md;
        logic       mc;
        int         kind, b1, b2;

        vecs[0] = '{8'hDC, 4'b1011, 1'b0, 1'b0, 2};
        vecs[1] = '{8'hCC, 4'b1011, 1'b1, 1'b0, 2};
        vecs[2] = '{8'hDE, 4'b1011, 1'b1, 1'b0, 2};
        vecs[3] = '{8'hDC, 4'b1011, 1'b0, 1'b0, 0};
        vecs[4] = '{8'hB4, 4'b0110, 1'b0, 1'b0, 2};
        vecs[5] = '{8'h5C, 4'b1011, 1'b0, 1'b1, 0};
        vecs[6] = '{8'h9C, 4'b1011, 1'b1, 1'b0, 1};
        vecs[7] = '{8'hFC, 4'b1011, 1'b1, 1'b0, 1};
        vecs[8] = '{8'hD8, 4'b1011, 1'b1, 1'b0, 1};
        vecs[9] = '{8'hD4, 4'b1011, 1'b1, 1'b0, 3};

        reset    = 1'b1;
        in       = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset state", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        monEn = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].frame, vecs[i].data, vecs[i].corr, vecs[i].drop, vecs[i].gap);
        end
        idle(8);
        @(negedge clk);
        checkVal("err_cnt after table", err_cnt, 32'd6);
        checkVal("saturated err_cnt after table", cntS, 32'd3);

        $display("[TB] partial frame then clean frame");
        sendPartial(5, 1'b1);
        applyStimulus(8'hDC, 4'b1011, 1'b0, 1'b0, 3);

        $display("[TB] reset mid-frame then clean frame");
        sendPartial(4, 1'b0);
        applyReset();
        applyStimulus(8'hDC, 4'b1011, 1'b0, 1'b0, 3);

        $display("[TB] random frames");
        for (int i = 0; i < 60; i++) begin
            d    = 4'($urandom_range(0, 15));
            f    = encode(d, 1'b1);
            kind = $urandom_range(0, 9);
            if (kind >= 3 && kind <= 6) begin
                b1 = $urandom_range(0, 6);
                f[b1] = ~f[b1];
            end else if (kind == 7) begin
                b1 = $urandom_range(0, 6);
                b2 = (b1 + $urandom_range(1, 6)) % 7;
                f[b1] = ~f[b1];
                f[b2] = ~f[b2];
            end else if (kind == 8) begin
                f[7] = 1'b0;
                b1 = $urandom_range(0, 7);
                if (b1 < 7) f[b1] = ~f[b1];
            end else if (kind == 9) begin
                sendPartial($urandom_range(1, 7), 1'b1);
            end
            nearest(f, md, mc);
            applyStimulus(f, md, mc, !f[7], $urandom_range(0, 3));
        end
        idle(8);

        $display("[TB] reset during output burst");
        applyStimulus(8'hCC, 4'b1011, 1'b1, 1'b0, 0);
        idle(2);
        applyReset();
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
